sram_burst_reader: RTL and testbench
====================================

SRAM_BURST_READER -- requirements
Module: sram_burst_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per SRAM entry.
REQ-002 SHALL have parameter N_ENTRIES, default 4096, SRAM depth.
REQ-003 SHALL have parameter ADDRW, default $clog2(N_ENTRIES), address width.
REQ-004 SHALL have parameter MAX_CHANNELS, default 64, lanes per SRAM access.
REQ-005 SHALL have parameter NUM_CHANNELS_WIDTH, default $clog2(MAX_CHANNELS+1), lane-count width.
REQ-006 SHALL have parameter LEN_WIDTH, default ADDRW+1, burst length width.
REQ-007 SHALL have clk_i  input  1  single clock, all logic on rising edge.
REQ-008 SHALL have rst_i  input  1  reset, synchronous, active-high.
REQ-009 SHALL have start_i  input  1  burst request, sampled only in IDLE.
REQ-010 SHALL have base_addr_i  input  ADDRW  first entry address, captured on accepted start.
REQ-011 SHALL have length_i  input  LEN_WIDTH  total entries to read, captured on accepted start.
REQ-012 SHALL have chan_i  input  NUM_CHANNELS_WIDTH  lanes per beat, captured on accepted start.
REQ-013 SHALL have sram_en_o / sram_we_o  output  1 / 1  SRAM port enable / write enable (we always 0).
REQ-014 SHALL have sram_num_channels_o  output  NUM_CHANNELS_WIDTH  lanes for current access.
REQ-015 SHALL have sram_addr_o  output  ADDRW*MAX_CHANNELS  flattened lane addresses, lane j at [ADDRW*(j+1)-1 -: ADDRW].
REQ-016 SHALL have sram_data_i  input  DATA_WIDTH*MAX_CHANNELS  SRAM read data, same lane packing.
REQ-017 SHALL have sram_ready_i  input  1  SRAM read data valid.
REQ-018 SHALL have data_o  output  DATA_WIDTH*MAX_CHANNELS  stream beat; valid_o / ready_i  1 / 1 handshake.
REQ-019 SHALL have lanes_o  output  NUM_CHANNELS_WIDTH  valid lanes in data_o; last_o  output  1  final beat.
REQ-020 SHALL have busy_o  output  1  burst in progress; done_o  output  1  one-cycle completion pulse.

Function
REQ-021 SHALL implement states IDLE, ISSUE, WAIT, HOLD, DONE.
REQ-022 IDLE: start_i=1 SHALL capture inputs, set pointer=base_addr_i, remaining=length_i; go ISSUE if length_i>0, else DONE.
REQ-023 chan_i=0 or chan_i>MAX_CHANNELS SHALL be clamped to MAX_CHANNELS at capture.
REQ-024 ISSUE (exactly one cycle): sram_en_o=1, sram_num_channels_o=n=min(chan,remaining), lane j<n address=(pointer+j) mod N_ENTRIES, lanes j>=n address 0; next WAIT.
REQ-025 WAIT: sram_en_o=0; on sram_ready_i=1 SHALL register data lanes j<n into data_o, zero lanes j>=n, set lanes_o=n, last_o=(remaining==n), valid_o=1; go HOLD; otherwise remain WAIT indefinitely.
REQ-026 HOLD: data_o, lanes_o, last_o, valid_o SHALL stay stable until valid_o&&ready_i.
REQ-027 On handshake: pointer+=n (mod N_ENTRIES, wraps 4095->0), remaining-=n, valid_o=0; next ISSUE if remaining>0, else DONE.
REQ-028 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-029 busy_o SHALL be 1 in ISSUE, WAIT, HOLD, DONE; 0 in IDLE.
REQ-030 start_i while busy_o=1 SHALL be ignored, no captured value altered.
REQ-031 Minimum beat period 3 cycles (ISSUE, WAIT with ready, HOLD with ready_i=1); at most one SRAM request outstanding.
REQ-032 sram_ready_i outside WAIT SHALL be ignored.

Reset
REQ-033 rst_i=1 at a rising edge SHALL force IDLE and zero all outputs (sram_en_o, sram_we_o, sram_num_channels_o, sram_addr_o, data_o, valid_o, lanes_o, last_o, busy_o, done_o) and internal pointer/remaining.
REQ-034 Reset mid-burst SHALL abandon the burst with no done_o pulse; rst_i SHALL take priority over start_i in the same cycle.

Verification
REQ-035 base=0, length=512, chan=64, ready_i=1, SRAM model 1-cycle: 8 beats, addresses 0..511 in order, lanes_o=64, last_o only on beat 8, one done_o.
REQ-036 base=4090, length=10, chan=64: one beat, lanes_o=10, lane addresses 4090..4095,0..3, lanes 10..63 of data_o zero, last_o=1.
REQ-037 base=100, length=70, chan=32: beats of 32,32,6 lanes at bases 100,132,164; last_o on third.
REQ-038 ready_i held 0 for 5 cycles in HOLD: data_o/lanes_o/last_o stable, no new sram_en_o pulse, progression resumes on ready_i=1.
REQ-039 length=0: no sram_en_o, done_o pulse in cycle after start; start_i during a burst ignored.
REQ-040 rst_i asserted in WAIT: next cycle all outputs 0, IDLE, no done_o; new start then runs normally.

Source files
------------

// File: rtl/sram_burst_reader.sv
// Burst reader: walks a multi-lane SRAM from a base address and streams the read data out
// as valid/ready beats of up to MAX_CHANNELS lanes each.
module sram_burst_reader #(
  parameter int DATA_WIDTH         = 8,
  parameter int N_ENTRIES          = 4096,
  parameter int ADDRW              = $clog2(N_ENTRIES),
  parameter int MAX_CHANNELS       = 64,
  parameter int NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS + 1),
  parameter int LEN_WIDTH          = ADDRW + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic [ADDRW-1:0]                   base_addr_i,
  input  logic [LEN_WIDTH-1:0]               length_i,
  input  logic [NUM_CHANNELS_WIDTH-1:0]      chan_i,
  output logic                               sram_en_o,
  output logic                               sram_we_o,
  output logic [NUM_CHANNELS_WIDTH-1:0]      sram_num_channels_o,
  output logic [ADDRW*MAX_CHANNELS-1:0]      sram_addr_o,
  input  logic [DATA_WIDTH*MAX_CHANNELS-1:0] sram_data_i,
  input  logic                               sram_ready_i,
  output logic [DATA_WIDTH*MAX_CHANNELS-1:0] data_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [NUM_CHANNELS_WIDTH-1:0]      lanes_o,
  output logic                               last_o,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CW = (LEN_WIDTH > NUM_CHANNELS_WIDTH) ? LEN_WIDTH : NUM_CHANNELS_WIDTH;
  localparam logic [NUM_CHANNELS_WIDTH-1:0] MaxCh = NUM_CHANNELS_WIDTH'(MAX_CHANNELS);

  logic [2:0]                          r_state;
  logic [ADDRW-1:0]                    r_ptr;
  logic [LEN_WIDTH-1:0]                r_rem;
  logic [NUM_CHANNELS_WIDTH-1:0]       r_chan;
  logic [DATA_WIDTH*MAX_CHANNELS-1:0]  r_data;
  logic [NUM_CHANNELS_WIDTH-1:0]       r_lanes;
  logic                                r_last;
  logic                                r_valid;

  logic [CW-1:0]                       w_chan_ext;
  logic [CW-1:0]                       w_rem_ext;
  logic [CW-1:0]                       w_n_ext;
  logic [NUM_CHANNELS_WIDTH-1:0]       w_n;
  logic                                w_last;
  logic [LEN_WIDTH-1:0]                w_rem_next;
  logic [ADDRW*MAX_CHANNELS-1:0]       w_addr;
  logic [DATA_WIDTH*MAX_CHANNELS-1:0]  w_data_masked;

  // Modular add; assumes off <= N_ENTRIES so one conditional subtract suffices.
  function automatic logic [ADDRW-1:0] wrap_add(input logic [ADDRW-1:0] p,
                                                input logic [31:0] off);
    logic [31:0] s;
    s = 32'(p) + off;
    if (s >= 32'(N_ENTRIES)) s = s - 32'(N_ENTRIES);
    return ADDRW'(s);
  endfunction

  assign w_chan_ext = CW'(r_chan);
  assign w_rem_ext  = CW'(r_rem);
  assign w_n_ext    = (w_rem_ext < w_chan_ext) ? w_rem_ext : w_chan_ext;
  assign w_n        = NUM_CHANNELS_WIDTH'(w_n_ext);
  assign w_last     = (w_rem_ext == w_n_ext);
  assign w_rem_next = r_rem - LEN_WIDTH'(w_n_ext);

  always_comb begin
    w_addr        = '0;
    w_data_masked = '0;
    for (int j = 0; j < MAX_CHANNELS; j++) begin
      if (NUM_CHANNELS_WIDTH'(j) < w_n) begin
        if (r_state == S_ISSUE) w_addr[ADDRW*j +: ADDRW] = wrap_add(r_ptr, 32'(j));
        w_data_masked[DATA_WIDTH*j +: DATA_WIDTH] = sram_data_i[DATA_WIDTH*j +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_chan  <= '0;
      r_data  <= '0;
      r_lanes <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_ptr   <= base_addr_i;
            r_rem   <= length_i;
            r_chan  <= (chan_i == '0 || chan_i > MaxCh) ? MaxCh : chan_i;
            r_state <= (length_i != '0) ? S_ISSUE : S_DONE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (sram_ready_i) begin
            r_data  <= w_data_masked;
            r_lanes <= w_n;
            r_last  <= w_last;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_ptr   <= wrap_add(r_ptr, 32'(w_n));
            r_rem   <= w_rem_next;
            r_state <= (w_rem_next != '0) ? S_ISSUE : S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sram_en_o           = (r_state == S_ISSUE);
  assign sram_we_o           = 1'b0;
  assign sram_num_channels_o = (r_state == S_ISSUE) ? w_n : '0;
  assign sram_addr_o         = w_addr;
  assign data_o              = r_data;
  assign valid_o             = r_valid;
  assign lanes_o             = r_lanes;
  assign last_o              = r_last;
  assign busy_o              = (r_state != S_IDLE);
  assign done_o              = (r_state == S_DONE);

endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader with a 1-cycle SRAM responder and a beat monitor.
module tb_sram_burst_reader;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int MC = 64;
  localparam int NW = 7;
  localparam int LW = 13;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [AW-1:0]    base = '0;
  logic [LW-1:0]    len = '0;
  logic [NW-1:0]    chan = '0;
  logic             en, we;
  logic [NW-1:0]    nch;
  logic [AW*MC-1:0] addr;
  logic [DW*MC-1:0] sdata = '0;
  logic             sready;
  logic [DW*MC-1:0] dout;
  logic             valid;
  logic             rdy = 1'b1;
  logic [NW-1:0]    lanes;
  logic             last, busy, done;

  logic stall = 1'b0;
  logic spur = 1'b0;
  logic pend_q = 1'b0;
  logic ready_q = 1'b0;

  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  logic [AW*MC-1:0] q_req_addr[$];
  logic [NW-1:0]    q_req_n[$];
  logic [DW*MC-1:0] q_data[$];
  logic [NW-1:0]    q_lanes[$];
  logic             q_last[$];

  sram_burst_reader dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .length_i(len),
    .chan_i(chan), .sram_en_o(en), .sram_we_o(we), .sram_num_channels_o(nch),
    .sram_addr_o(addr), .sram_data_i(sdata), .sram_ready_i(sready), .data_o(dout),
    .valid_o(valid), .ready_i(rdy), .lanes_o(lanes), .last_o(last), .busy_o(busy),
    .done_o(done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW*MC-1:0] mem_read(input logic [AW*MC-1:0] a);
    logic [DW*MC-1:0] v;
    for (int j = 0; j < MC; j++) v[DW*j +: DW] = a[AW*j +: DW] ^ 8'h5A;
    return v;
  endfunction

  function automatic logic [AW*MC-1:0] exp_addr(input int b, input int n);
    logic [AW*MC-1:0] v = '0;
    for (int j = 0; j < n; j++) v[AW*j +: AW] = AW'((b + j) % 4096);
    return v;
  endfunction

  function automatic logic [DW*MC-1:0] exp_data(input int b, input int n);
    logic [DW*MC-1:0] v = '0;
    for (int j = 0; j < n; j++) v[DW*j +: DW] = 8'(((b + j) % 4096) & 255) ^ 8'h5A;
    return v;
  endfunction

  // SRAM responder: one cycle of latency unless stalled, then answers the pending request.
  assign sready = ready_q | spur;
  always @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (en) begin
        pend_q <= 1'b1;
        sdata  <= mem_read(addr);
      end
      if ((en || pend_q) && !stall) begin
        ready_q <= 1'b1;
        pend_q  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      q_req_addr.push_back(addr);
      q_req_n.push_back(nch);
    end
    if (valid && rdy) begin
      q_data.push_back(dout);
      q_lanes.push_back(lanes);
      q_last.push_back(last);
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic clear_mon();
    q_req_addr.delete(); q_req_n.delete();
    q_data.delete(); q_lanes.delete(); q_last.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic do_start(input int b, input int l, input int c);
    @(posedge clk); #1;
    start = 1'b1; base = AW'(b); len = LW'(l); chan = NW'(c);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && done_cnt == 0; i++) @(negedge clk);
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; len = 13'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({en, we, busy, done, valid, last} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {en, we, busy, done, valid, last});
    else n_pass++;
    n_checks++;
    if ({nch, lanes} !== 14'd0) $display("FAIL reset_counts: got %h want 0", {nch, lanes});
    else n_pass++;
    n_checks++;
    if (addr !== '0) $display("FAIL reset_addr: got %h want 0", addr);
    else n_pass++;
    n_checks++;
    if (dout !== '0) $display("FAIL reset_data: got %h want 0", dout);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_spurious_ready();
    @(posedge clk); #1 spur = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({valid, busy} !== 2'b00) $display("FAIL spur_idle: got %b want 00", {valid, busy});
    else n_pass++;
    @(posedge clk); #1 spur = 1'b0;
  endtask

  task automatic test_full_burst();
    clear_mon(); rdy = 1'b1;
    do_start(0, 512, 64);
    wait_idle();
    n_checks++;
    if (done_cnt !== 1) $display("FAIL full_done: got %0d want 1", done_cnt); else n_pass++;
    n_checks++;
    if (busy_cnt !== 25) $display("FAIL full_busy_cycles: got %0d want 25", busy_cnt);
    else n_pass++;
    n_checks++;
    if (q_req_n.size() !== 8 || q_data.size() !== 8)
      $display("FAIL full_counts: got %0d/%0d want 8/8", q_req_n.size(), q_data.size());
    else n_pass++;
    for (int k = 0; k < 8 && k < q_data.size(); k++) begin
      n_checks++;
      if ({q_req_n[k], q_req_addr[k]} !== {7'd64, exp_addr(64 * k, 64)})
        $display("FAIL full_req%0d: got %h want %h", k, {q_req_n[k], q_req_addr[k]},
                 {7'd64, exp_addr(64 * k, 64)});
      else n_pass++;
      n_checks++;
      if ({q_lanes[k], q_last[k], q_data[k]} !== {7'd64, 1'(k == 7), exp_data(64 * k, 64)})
        $display("FAIL full_beat%0d: got %h want %h", k, {q_lanes[k], q_last[k], q_data[k]},
                 {7'd64, 1'(k == 7), exp_data(64 * k, 64)});
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    clear_mon();
    do_start(4090, 10, 64);
    wait_idle();
    n_checks++;
    if (q_req_n.size() !== 1 || q_data.size() !== 1 || done_cnt !== 1)
      $display("FAIL wrap_counts: got %0d/%0d/%0d want 1/1/1", q_req_n.size(), q_data.size(),
               done_cnt);
    else n_pass++;
    n_checks++;
    if ({q_req_n[0], q_req_addr[0]} !== {7'd10, exp_addr(4090, 10)})
      $display("FAIL wrap_req: got %h want %h", {q_req_n[0], q_req_addr[0]},
               {7'd10, exp_addr(4090, 10)});
    else n_pass++;
    n_checks++;
    if ({q_lanes[0], q_last[0], q_data[0]} !== {7'd10, 1'b1, exp_data(4090, 10)})
      $display("FAIL wrap_beat: got %h want %h", {q_lanes[0], q_last[0], q_data[0]},
               {7'd10, 1'b1, exp_data(4090, 10)});
    else n_pass++;
  endtask

  task automatic test_partial();
    int exp_n[3] = '{32, 32, 6};
    clear_mon();
    do_start(100, 70, 32);
    wait_idle();
    n_checks++;
    if (q_req_n.size() !== 3 || q_data.size() !== 3 || done_cnt !== 1)
      $display("FAIL part_counts: got %0d/%0d/%0d want 3/3/1", q_req_n.size(), q_data.size(),
               done_cnt);
    else n_pass++;
    for (int k = 0; k < 3 && k < q_data.size(); k++) begin
      n_checks++;
      if ({q_req_n[k], q_req_addr[k]} !== {7'(exp_n[k]), exp_addr(100 + 32 * k, exp_n[k])})
        $display("FAIL part_req%0d: got %h want %h", k, {q_req_n[k], q_req_addr[k]},
                 {7'(exp_n[k]), exp_addr(100 + 32 * k, exp_n[k])});
      else n_pass++;
      n_checks++;
      if ({q_lanes[k], q_last[k], q_data[k]} !==
          {7'(exp_n[k]), 1'(k == 2), exp_data(100 + 32 * k, exp_n[k])})
        $display("FAIL part_beat%0d: got %h want %h", k, {q_lanes[k], q_last[k], q_data[k]},
                 {7'(exp_n[k]), 1'(k == 2), exp_data(100 + 32 * k, exp_n[k])});
      else n_pass++;
    end
  endtask

  task automatic test_clamp();
    clear_mon();
    do_start(0, 70, 0);
    wait_idle();
    n_checks++;
    if (q_req_n.size() !== 2 || q_req_n[0] !== 7'd64 || q_req_n[1] !== 7'd6)
      $display("FAIL clamp_zero: got %0d reqs first n %0d want 2 reqs first n 64",
               q_req_n.size(), q_req_n[0]);
    else n_pass++;
    clear_mon();
    do_start(1000, 65, 100);
    wait_idle();
    n_checks++;
    if (q_req_n.size() !== 2 || q_req_n[0] !== 7'd64 || q_req_n[1] !== 7'd1)
      $display("FAIL clamp_big: got %0d reqs first n %0d want 2 reqs first n 64",
               q_req_n.size(), q_req_n[0]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    clear_mon(); rdy = 1'b0;
    do_start(200, 20, 8);
    for (int i = 0; i < 50 && !valid; i++) @(negedge clk);
    n_checks++;
    if (valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", valid); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({valid, lanes, last, dout} !== {1'b1, 7'd8, 1'b0, exp_data(200, 8)})
        $display("FAIL bp_hold%0d: got %h want %h", c, {valid, lanes, last, dout},
                 {1'b1, 7'd8, 1'b0, exp_data(200, 8)});
      else n_pass++;
    end
    n_checks++;
    if (q_req_n.size() !== 1) $display("FAIL bp_no_reissue: got %0d want 1", q_req_n.size());
    else n_pass++;
    @(posedge clk); #1 rdy = 1'b1;
    wait_idle();
    n_checks++;
    if (q_data.size() !== 3 || done_cnt !== 1)
      $display("FAIL bp_resume: got %0d beats %0d done want 3/1", q_data.size(), done_cnt);
    else n_pass++;
    n_checks++;
    if ({q_lanes[2], q_last[2], q_data[2]} !== {7'd4, 1'b1, exp_data(216, 4)})
      $display("FAIL bp_last: got %h want %h", {q_lanes[2], q_last[2], q_data[2]},
               {7'd4, 1'b1, exp_data(216, 4)});
    else n_pass++;
  endtask

  task automatic test_wait_stall();
    clear_mon(); stall = 1'b1; rdy = 1'b1;
    do_start(50, 5, 8);
    repeat (6) @(negedge clk);
    n_checks++;
    if ({valid, busy, en} !== 3'b010 || q_req_n.size() !== 1)
      $display("FAIL stall_wait: got %b reqs %0d want 010 reqs 1", {valid, busy, en},
               q_req_n.size());
    else n_pass++;
    @(posedge clk); #1 stall = 1'b0;
    wait_idle();
    n_checks++;
    if (q_data.size() !== 1 || {q_lanes[0], q_last[0], q_data[0]} !== {7'd5, 1'b1,
        exp_data(50, 5)})
      $display("FAIL stall_beat: got %h want %h", {q_lanes[0], q_last[0], q_data[0]},
               {7'd5, 1'b1, exp_data(50, 5)});
    else n_pass++;
  endtask

  task automatic test_zero_len();
    clear_mon();
    do_start(7, 0, 4);
    @(negedge clk);
    n_checks++;
    if ({done, busy, en} !== 3'b110) $display("FAIL zero_done: got %b want 110",
                                              {done, busy, en});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) $display("FAIL zero_idle: got %b want 00", {done, busy});
    else n_pass++;
    n_checks++;
    if (q_req_n.size() !== 0 || done_cnt !== 1)
      $display("FAIL zero_counts: got %0d reqs %0d done want 0/1", q_req_n.size(), done_cnt);
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    clear_mon(); rdy = 1'b0;
    do_start(300, 16, 16);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1; base = 12'd0; len = 13'd1000; chan = 7'd1;
    @(posedge clk); #1;
    start = 1'b0; rdy = 1'b1;
    wait_idle();
    n_checks++;
    if (q_req_n.size() !== 1 || q_data.size() !== 1 || done_cnt !== 1)
      $display("FAIL ign_counts: got %0d/%0d/%0d want 1/1/1", q_req_n.size(), q_data.size(),
               done_cnt);
    else n_pass++;
    n_checks++;
    if ({q_req_n[0], q_req_addr[0]} !== {7'd16, exp_addr(300, 16)})
      $display("FAIL ign_req: got %h want %h", {q_req_n[0], q_req_addr[0]},
               {7'd16, exp_addr(300, 16)});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_mon(); stall = 1'b1; rdy = 1'b1;
    do_start(500, 40, 16);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, en, valid} !== 3'b100 || q_req_n.size() !== 1)
      $display("FAIL rmid_wait: got %b reqs %0d want 100 reqs 1", {busy, en, valid},
               q_req_n.size());
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; base = 12'd9; len = 13'd3; chan = 7'd3;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({en, we, busy, done, valid, last, nch, lanes} !== 20'd0 || addr !== '0 || dout !== '0)
      $display("FAIL rmid_zero: got %b want 0", {en, we, busy, done, valid, last, nch, lanes});
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_cnt !== 0 || q_data.size() !== 0 || busy !== 1'b0)
      $display("FAIL rmid_abandon: got done %0d beats %0d busy %b want 0 0 0", done_cnt,
               q_data.size(), busy);
    else n_pass++;
    clear_mon();
    do_start(10, 4, 4);
    wait_idle();
    n_checks++;
    if (done_cnt !== 1 || q_data.size() !== 1 ||
        {q_lanes[0], q_last[0], q_data[0]} !== {7'd4, 1'b1, exp_data(10, 4)})
      $display("FAIL rmid_restart: got %h want %h", {q_lanes[0], q_last[0], q_data[0]},
               {7'd4, 1'b1, exp_data(10, 4)});
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spurious_ready();
    test_full_burst();
    test_wrap();
    test_partial();
    test_clamp();
    test_backpressure();
    test_wait_stall();
    test_zero_len();
    test_ignore_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
